// File: rtl/clb_cfg_sequencer_if.sv
// Bitstream stream plus per-CLB configuration bundle between the fabric and the CLB chain.
interface clb_cfg_sequencer_if #(
    parameter int unsigned NUM_CLBS             = 4,
    parameter int unsigned BITSTREAM_DATA_WIDTH = 8
);
    logic [BITSTREAM_DATA_WIDTH-1:0] s_tdata;
    logic                            s_tvalid;
    logic                            s_tlast;
    logic                            s_tready;
    logic [BITSTREAM_DATA_WIDTH-1:0] m_tdata;
    logic                            m_tlast;
    logic [NUM_CLBS-1:0]             m_tvalid;
    logic [NUM_CLBS-1:0]             m_tready;
    logic [NUM_CLBS-1:0]             clb_cfg;
    logic [NUM_CLBS-1:0]             clb_cfg_ready;

    // Sequencer side
    modport slave (
        input  s_tdata, s_tvalid, s_tlast, m_tready, clb_cfg_ready,
        output s_tready, m_tdata, m_tlast, m_tvalid, clb_cfg
    );

    // Bitstream source / CLB chain side
    modport master (
        output s_tdata, s_tvalid, s_tlast, m_tready, clb_cfg_ready,
        input  s_tready, m_tdata, m_tlast, m_tvalid, clb_cfg
    );
endinterface

// File: rtl/clb_cfg_sequencer.sv
// Loads a chain of CLBs from one AXI-stream bitstream, one tlast-terminated frame per CLB,
// pulsing each CLB's cfg and waiting for its config-ready before moving on.
module clb_cfg_sequencer #(
    parameter  int unsigned NUM_CLBS             = 4,
    parameter  int unsigned BITSTREAM_DATA_WIDTH = 8,
    parameter  int unsigned READY_TIMEOUT        = 255,
    localparam int unsigned SEL_W                = $clog2(NUM_CLBS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_start,
    input  logic                 abort,
    clb_cfg_sequencer_if.slave   bus,
    output logic [SEL_W-1:0]     clb_sel,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam int unsigned        CNT_W    = $clog2(READY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(READY_TIMEOUT);
    localparam logic [SEL_W-1:0]   LAST_SEL = SEL_W'(NUM_CLBS - 1);
    localparam logic [NUM_CLBS-1:0] ONE_HOT0 = {{(NUM_CLBS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_BEGIN,
        S_STREAM,
        S_WAIT_RDY,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                state_q, state_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_CLBS-1:0]   clb_cfg_q;
    logic                  busy_q, done_q, error_q;

    logic [BITSTREAM_DATA_WIDTH-1:0] tdata;
    logic                            stream_ready;
    logic                            xfer;

    assign tdata        = bus.s_tdata;
    assign stream_ready = (state_q == S_STREAM) && bus.m_tready[sel_q];
    assign xfer         = bus.s_tvalid && stream_ready;

    // Next-state logic; abort overrides every other transition
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        if (abort) begin
            state_d = S_IDLE;
            sel_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (cfg_start) begin
                        state_d = S_BEGIN;
                        sel_d   = '0;
                    end
                end
                S_BEGIN: begin
                    state_d = S_STREAM;
                end
                S_STREAM: begin
                    if (xfer && bus.s_tlast) begin
                        state_d = S_WAIT_RDY;
                        cnt_d   = '0;
                    end
                end
                S_WAIT_RDY: begin
                    if (bus.clb_cfg_ready[sel_q]) begin
                        if (sel_q == LAST_SEL) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_BEGIN;
                            sel_d   = sel_q + SEL_W'(1);
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = S_ERROR;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    sel_d   = '0;
                end
            endcase
        end
    end

    // State register and registered status outputs derived from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sel_q     <= '0;
            cnt_q     <= '0;
            clb_cfg_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            clb_cfg_q <= (state_d == S_BEGIN) ? (ONE_HOT0 << sel_d) : '0;
            busy_q    <= (state_d == S_BEGIN) || (state_d == S_STREAM) ||
                         (state_d == S_WAIT_RDY);
            done_q    <= (state_d == S_DONE);
            error_q   <= (state_d == S_ERROR);
        end
    end

    // Zero-latency passthrough; valid only reaches the selected CLB while streaming
    always_comb begin
        bus.m_tvalid = '0;
        if (state_q == S_STREAM) begin
            bus.m_tvalid[sel_q] = bus.s_tvalid;
        end
    end

    assign bus.s_tready = stream_ready;
    assign bus.m_tdata  = tdata;
    assign bus.m_tlast  = bus.s_tlast;
    assign bus.clb_cfg  = clb_cfg_q;
    assign clb_sel      = sel_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;

endmodule
